// File: rtl/full_subtractor1_if.sv
// ----------------------------------------------------------------------------
// full_subtractor1_if
//   Operand / result bundle for the registered full subtractor.
//   master : drives in_valid, a, b, bin; observes out_valid, d, bout
//   slave  : the subtractor itself (consumes operands, produces results)
// Signals
//   in_valid  1      a/b/bin are valid this cycle
//   a         WIDTH  minuend, unsigned
//   b         WIDTH  subtrahend, unsigned
//   bin       1      borrow-in, weight 1 at bit 0
//   out_valid 1      d/bout hold a fresh result
//   d         WIDTH  difference, modulo 2^WIDTH
//   bout      1      borrow-out from the MSB
// ----------------------------------------------------------------------------
interface full_subtractor1_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output in_valid, a, b, bin,
        input  out_valid, d, bout
    );

    modport slave (
        input  in_valid, a, b, bin,
        output out_valid, d, bout
    );
endinterface

// File: rtl/full_subtractor1.sv
// ----------------------------------------------------------------------------
// full_subtractor1
//   Registered ripple-borrow full subtractor: {bout, d} = a - b - bin.
//   One-cycle latency, one result per cycle, no back-pressure. With WIDTH=1
//   this is the classic 1-bit full subtractor; wider slices chain through
//   bin/bout. Legal WIDTH range is 1..64.
// Ports
//   clk     input  rising-edge clock
//   rst_n   input  asynchronous active-low reset; clears d, bout, out_valid
//   sub_if  slave  operand/result bundle (see full_subtractor1_if)
// ----------------------------------------------------------------------------
module full_subtractor1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    full_subtractor1_if.slave  sub_if
);

    // Borrow chain: w_br[0] is the external borrow-in, w_br[WIDTH] leaves the MSB.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_valid;

    assign w_br[0] = sub_if.bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_axb;
        assign w_axb       = sub_if.a[i] ^ sub_if.b[i];
        assign w_diff[i]   = w_axb ^ w_br[i];
        // Borrow when b beats a outright, or when they tie and a borrow is pending.
        assign w_br[i+1]   = (~sub_if.a[i] & sub_if.b[i]) | (~w_axb & w_br[i]);
    end

    // Result flops load only on accepted operands, so idle-cycle inputs
    // (including X) never reach d/bout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= sub_if.in_valid;
            if (sub_if.in_valid) begin
                r_d    <= w_diff;
                r_bout <= w_br[WIDTH];
            end
        end
    end

    assign sub_if.d         = r_d;
    assign sub_if.bout      = r_bout;
    assign sub_if.out_valid = r_valid;

endmodule

// File: tb/tb_full_subtractor1.sv
module tb_full_subtractor1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    full_subtractor1_if #(.WIDTH(1)) if1 ();
    full_subtractor1_if #(.WIDTH(8)) if8 ();
    full_subtractor1_if #(.WIDTH(4)) if_lo ();
    full_subtractor1_if #(.WIDTH(4)) if_hi ();

    full_subtractor1 #(.WIDTH(1)) u_dut1  (.clk(clk), .rst_n(rst_n), .sub_if(if1));
    full_subtractor1 #(.WIDTH(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .sub_if(if8));
    full_subtractor1 #(.WIDTH(4)) u_dut_lo (.clk(clk), .rst_n(rst_n), .sub_if(if_lo));
    full_subtractor1 #(.WIDTH(4)) u_dut_hi (.clk(clk), .rst_n(rst_n), .sub_if(if_hi));

    // Registered borrow: the high slice consumes it one cycle after the low slice.
    assign if_hi.bin = if_lo.bout;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       bout;
    } exp_t;

    exp_t       q8[$];
    exp_t       q1[$];
    exp_t       e8;
    exp_t       e1;
    logic [7:0] hold8_d = '0;
    logic       hold8_b = 1'b0;
    logic       hold1_d = 1'b0;
    logic       hold1_b = 1'b0;

    // Scoreboard monitors: a result is due exactly one cycle after it was driven;
    // on every other cycle out_valid must be low and d/bout must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            hold8_d = '0;
            hold8_b = 1'b0;
        end else if (q8.size() != 0 && q8[0].due == cyc) begin
            e8 = q8.pop_front();
            check("w8_valid", 64'(if8.out_valid), 64'd1);
            check("w8_d", 64'(if8.d), 64'(e8.d));
            check("w8_bout", 64'(if8.bout), 64'(e8.bout));
            hold8_d = e8.d;
            hold8_b = e8.bout;
        end else begin
            check("w8_idle_valid", 64'(if8.out_valid), 64'd0);
            check("w8_hold_d", 64'(if8.d), 64'(hold8_d));
            check("w8_hold_bout", 64'(if8.bout), 64'(hold8_b));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            hold1_d = 1'b0;
            hold1_b = 1'b0;
        end else if (q1.size() != 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            check("w1_valid", 64'(if1.out_valid), 64'd1);
            check("w1_d", 64'(if1.d), 64'(e1.d));
            check("w1_bout", 64'(if1.bout), 64'(e1.bout));
            hold1_d = e1.d[0];
            hold1_b = e1.bout;
        end else begin
            check("w1_idle_valid", 64'(if1.out_valid), 64'd0);
            check("w1_hold_d", 64'(if1.d), 64'(hold1_d));
            check("w1_hold_bout", 64'(if1.bout), 64'(hold1_b));
        end
    end

    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        if8.in_valid = v;
        if8.a        = a;
        if8.b        = b;
        if8.bin      = bin;
        if (v) begin
            e.due  = cyc + 1;
            e.d    = ed;
            e.bout = eb;
            q8.push_back(e);
        end
    endtask

    task automatic step1(input logic v, input logic a, input logic b, input logic bin,
                         input logic ed, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        if1.in_valid = v;
        if1.a        = a;
        if1.b        = b;
        if1.bin      = bin;
        if (v) begin
            e.due  = cyc + 1;
            e.d    = {7'd0, ed};
            e.bout = eb;
            q1.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [1:0] tt_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        logic [2:0] v3;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [8:0] rres;

        // Reset held with busy inputs: outputs must stay cleared.
        rst_n = 1'b0;
        if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.bin = 1'b0;
        if8.in_valid = 1'b1; if8.a = 8'h00; if8.b = 8'hFF; if8.bin = 1'b1;
        if_lo.in_valid = 1'b1; if_lo.a = 4'h0; if_lo.b = 4'hF; if_lo.bin = 1'b1;
        if_hi.in_valid = 1'b1; if_hi.a = 4'h0; if_hi.b = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_w8_d", 64'(if8.d), 64'd0);
        check("rst_w8_bout", 64'(if8.bout), 64'd0);
        check("rst_w8_valid", 64'(if8.out_valid), 64'd0);
        check("rst_w1_d", 64'(if1.d), 64'd0);
        check("rst_w1_valid", 64'(if1.out_valid), 64'd0);
        check("rst_lo_bout", 64'(if_lo.bout), 64'd0);
        check("rst_hi_valid", 64'(if_hi.out_valid), 64'd0);
        if1.in_valid = 1'b0;
        if8.in_valid = 1'b0;
        if_lo.in_valid = 1'b0;
        if_hi.in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // WIDTH=1 truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            v3 = 3'(i);
            step1(1'b1, v3[2], v3[1], v3[0], tt_exp[i][1], tt_exp[i][0]);
        end
        step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hold: single pulse, then changing inputs with in_valid low.
        step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // WIDTH=8 boundaries, back-to-back.
        step8(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        step8(1'b1, 8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0);
        step8(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        step8(1'b0, 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b0);

        // Eight consecutive random vectors against the arithmetic reference.
        for (int i = 0; i < 8; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            rres = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            step8(1'b1, ra, rb, rbin, rres[7:0], rres[8]);
        end
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset with a result in flight.
        step8(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        step8(1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        #2;
        rst_n = 1'b0;
        if8.in_valid = 1'b0;
        #1;
        check("async_rst_d", 64'(if8.d), 64'd0);
        check("async_rst_bout", 64'(if8.bout), 64'd0);
        check("async_rst_valid", 64'(if8.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        step8(1'b1, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Chain two 4-bit slices against one 8-bit instance.
        step8(1'b1, 8'h30, 8'h0F, 1'b0, 8'h21, 1'b0);
        if_lo.in_valid = 1'b1; if_lo.a = 4'h0; if_lo.b = 4'hF; if_lo.bin = 1'b0;
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        if_lo.in_valid = 1'b0;
        if_hi.in_valid = 1'b1; if_hi.a = 4'h3; if_hi.b = 4'h0;
        step8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        if_hi.in_valid = 1'b0;
        check("chain_d", 64'({if_hi.d, if_lo.d}), 64'h21);
        check("chain_bout", 64'(if_hi.bout), 64'd0);
        check("chain_valid", 64'(if_hi.out_valid), 64'd1);
        check("chain_lo_bout", 64'(if_lo.bout), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("drain_q8", 64'(q8.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
